// File: rtl/register_file_sb.sv
// Register file for the pipelined core: two combinational read ports, one
// synchronous write port, x0 hard-wired to zero. Adds an optional
// write-to-read bypass, a per-register busy scoreboard and a sequential clear
// engine that re-zeroes the file without a reset.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   a1/rd1/rd1_busy     read port 1: address, data, pending-write flag
//   a2/rd2/rd2_busy     read port 2: address, data, pending-write flag
//   we3/a3/wd3          write port: enable, address, data
//   issue_en/issue_rd   issued instruction marks its destination busy
//   clr_start/clr_busy  clear engine start pulse and activity flag
//   a0                  stored contents of register DEBUG_REG (no bypass)
module register_file_sb #(
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter bit          BYPASS        = 1'b1,
  parameter int unsigned DEBUG_REG     = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDRESS_WIDTH-1:0] a1,
  input  logic [ADDRESS_WIDTH-1:0] a2,
  output logic [DATA_WIDTH-1:0]    rd1,
  output logic [DATA_WIDTH-1:0]    rd2,
  output logic                     rd1_busy,
  output logic                     rd2_busy,
  input  logic                     we3,
  input  logic [ADDRESS_WIDTH-1:0] a3,
  input  logic [DATA_WIDTH-1:0]    wd3,
  input  logic                     issue_en,
  input  logic [ADDRESS_WIDTH-1:0] issue_rd,
  input  logic                     clr_start,
  output logic                     clr_busy,
  output logic [DATA_WIDTH-1:0]    a0
);

  localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_IDX = ADDRESS_WIDTH'(DEPTH - 1);
  localparam logic [ADDRESS_WIDTH-1:0] DBG_IDX  = ADDRESS_WIDTH'(DEBUG_REG);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]    mem_q [DEPTH];
  logic [DEPTH-1:0]         busy_q, busy_d;
  logic                     wr_live;
  logic                     hit1, hit2;

  // Clear engine state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Clear engine next state: walks indices 1..DEPTH-1, then back to IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d = CLEAR;
          cnt_d   = ADDRESS_WIDTH'(1);
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + ADDRESS_WIDTH'(1);
        if (cnt_q == LAST_IDX) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign clr_busy = (state_q == CLEAR);

  // Port-3 activity is suppressed while the clear engine owns the file
  assign wr_live = we3 && !clr_busy;

  // Storage: clear engine has priority over the write port; x0 never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr_busy) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_live && (a3 != '0)) begin
      mem_q[a3] <= wd3;
    end
  end

  // Scoreboard next value: issue set is applied after write clear so it wins
  always_comb begin
    busy_d = busy_q;
    if (clr_busy) begin
      busy_d[cnt_q] = 1'b0;
    end else begin
      if (we3) busy_d[a3] = 1'b0;
      if (issue_en) busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // Read ports with optional same-cycle forwarding
  assign hit1 = BYPASS && wr_live && (a3 == a1);
  assign hit2 = BYPASS && wr_live && (a3 == a2);

  assign rd1 = (a1 == '0) ? '0 : (hit1 ? wd3 : mem_q[a1]);
  assign rd2 = (a2 == '0) ? '0 : (hit2 ? wd3 : mem_q[a2]);

  // busy_q[0] is always 0, so reads of x0 never report a hazard
  assign rd1_busy = busy_q[a1] && !hit1;
  assign rd2_busy = busy_q[a2] && !hit2;

  // mem_q[0] is always 0, which covers DEBUG_REG == 0
  assign a0 = mem_q[DBG_IDX];

endmodule
